// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator feeding a DEPTH-entry prefetch queue
// with branch-redirect flush, committed halt and fetch-side halt on HALT_OP.
module fetch_queue #(
  parameter int         PC_W     = 8,
  parameter int         INSTR_W  = 32,
  parameter int         DEPTH    = 4,
  parameter int         RESET_PC = 0,
  parameter int         PC_STEP  = 4,
  parameter logic [6:0] HALT_OP  = 7'h7F
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [INSTR_W-1:0]           imem_data,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic                         halt,
  output logic                         out_valid,
  output logic [PC_W-1:0]              out_pc,
  output logic [INSTR_W-1:0]           out_instr,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               halted_q, halted_d;
  logic               fetch_stop_q, fetch_stop_d;
  logic [PC_W-1:0]    mem_pc_q    [DEPTH];
  logic [PC_W-1:0]    mem_pc_d    [DEPTH];
  logic [INSTR_W-1:0] mem_instr_q [DEPTH];
  logic [INSTR_W-1:0] mem_instr_d [DEPTH];

  logic pop;
  logic can_push;
  logic push;

  assign out_valid = (count_q != '0);
  assign out_pc    = mem_pc_q[rd_q];
  assign out_instr = mem_instr_q[rd_q];
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign halted    = halted_q;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    pop          = out_valid & out_ready;
    can_push     = ~halted_q & ~fetch_stop_q & ((count_q < CW'(DEPTH)) | pop);
    push         = can_push & ~redirect_valid;
    fetch_pc_d   = fetch_pc_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    count_d      = count_q;
    fetch_stop_d = fetch_stop_q;
    halted_d     = halted_q | halt;
    mem_pc_d     = mem_pc_q;
    mem_instr_d  = mem_instr_q;

    if (redirect_valid) begin
      // Flush wins over everything; the head is dropped even if decode took it.
      rd_d         = '0;
      wr_d         = '0;
      count_d      = '0;
      fetch_pc_d   = redirect_pc;
      fetch_stop_d = 1'b0;
    end else begin
      if (push) begin
        mem_pc_d[wr_q]    = fetch_pc_q;
        mem_instr_d[wr_q] = imem_data;
        wr_d              = wr_q + AW'(1);
        fetch_pc_d        = fetch_pc_q + PC_W'(PC_STEP);
        if (imem_data[6:0] == HALT_OP) fetch_stop_d = 1'b1;
      end
      if (pop) rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= PC_W'(RESET_PC);
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      halted_q     <= 1'b0;
      fetch_stop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      halted_q     <= halted_d;
      fetch_stop_q <= fetch_stop_d;
      mem_pc_q     <= mem_pc_d;
      mem_instr_q  <= mem_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run
// against a queue-based reference model of the fetch front end.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic        out_valid;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;
  logic        full;
  logic        halted;

  logic [31:0] rom [256];
  assign imem_data = rom[imem_addr];

  fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count), .full(full), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } ent_t;

  ent_t       m_q[$];
  logic [7:0] m_fpc;
  logic       m_halted;
  logic       m_stop;

  task automatic model_reset();
    m_q.delete();
    m_fpc    = 8'h00;
    m_halted = 1'b0;
    m_stop   = 1'b0;
  endtask

  // Advance the reference model by one clock using the currently driven inputs,
  // then move the DUT one edge and return on the following falling edge.
  task automatic cycle();
    bit   pop, do_push;
    ent_t e;
    pop = (m_q.size() > 0) && out_ready;
    if (redirect_valid) begin
      m_q.delete();
      m_fpc  = redirect_pc;
      m_stop = 1'b0;
    end else begin
      do_push = !m_halted && !m_stop && ((m_q.size() < DEPTH) || pop);
      if (pop) void'(m_q.pop_front());
      if (do_push) begin
        e.pc    = m_fpc;
        e.instr = rom[m_fpc];
        m_q.push_back(e);
        if (rom[m_fpc][6:0] == 7'h7F) m_stop = 1'b1;
        m_fpc = m_fpc + 8'd4;
      end
    end
    if (halt) m_halted = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rom_identity();
    for (int a = 0; a < 256; a++) rom[a] = 32'(a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    halt           = 1'b0;
    out_ready      = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0h exp 0", full); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0h exp 0", halted); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_imem_addr got %0h exp 0", imem_addr); end
    checks++; if (out_pc !== 8'h00 || out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_data got %0h/%0h exp 0/0", out_pc, out_instr); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++; if (out_valid !== 1'b1 || out_pc !== 8'(4*i)) begin errors++; $display("FAIL stream_pc[%0d] got v=%0h pc=%0h exp v=1 pc=%0h", i, out_valid, out_pc, 8'(4*i)); end
      checks++; if (out_instr !== 32'(4*i)) begin errors++; $display("FAIL stream_instr[%0d] got %0h exp %0h", i, out_instr, 32'(4*i)); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count); end
    end
  endtask

  task automatic test_backpressure();
    int exp_c;
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      exp_c = (i < DEPTH) ? i : DEPTH;
      checks++; if (count !== 3'(exp_c)) begin errors++; $display("FAIL bp_count[%0d] got %0d exp %0d", i, count, exp_c); end
      if (i >= DEPTH) begin
        checks++; if (full !== 1'b1 || imem_addr !== 8'd16) begin errors++; $display("FAIL bp_full_addr[%0d] got full=%0h addr=%0h exp full=1 addr=10", i, full, imem_addr); end
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 8'(4*k)) begin errors++; $display("FAIL bp_drain[%0d] got v=%0h pc=%0h exp v=1 pc=%0h", k, out_valid, out_pc, 8'(4*k)); end
      cycle();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    repeat (3) cycle();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL redir_pre_count got %0d exp 3", count); end
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    out_ready      = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got count=%0d v=%0h exp 0/0", count, out_valid); end
    cycle();
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h40) begin errors++; $display("FAIL redir_target got v=%0h pc=%0h exp 1/40", out_valid, out_pc); end
  endtask

  task automatic test_fetch_halt();
    rom[8] = 32'h0000007F;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (out_valid !== 1'b1 || out_pc !== 8'(4*i)) begin errors++; $display("FAIL fh_pc[%0d] got v=%0h pc=%0h exp 1/%0h", i, out_valid, out_pc, 8'(4*i)); end
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fh_stopped[%0d] got v=%0h exp 0", i, out_valid); end
    end
    checks++; if (imem_addr !== 8'd12) begin errors++; $display("FAIL fh_addr got %0h exp c", imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 8'h20;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h20) begin errors++; $display("FAIL fh_resume got v=%0h pc=%0h exp 1/20", out_valid, out_pc); end
    cycle();
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h24) begin errors++; $display("FAIL fh_resume2 got v=%0h pc=%0h exp 1/24", out_valid, out_pc); end
    rom[8] = 32'd8;
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b0;
    repeat (2) cycle();
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_latched got %0h exp 1", halted); end
    // The fetch in the halt cycle itself still lands, so three entries drain.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 8'(4*k)) begin errors++; $display("FAIL halt_drain[%0d] got v=%0h pc=%0h exp 1/%0h", k, out_valid, out_pc, 8'(4*k)); end
      cycle();
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_empty[%0d] got v=%0h exp 0", k, out_valid); end
      cycle();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    cycle();
    redirect_valid = 1'b0;
    repeat (3) begin
      checks++; if (out_valid !== 1'b0 || imem_addr !== 8'h10 || halted !== 1'b1) begin errors++; $display("FAIL halt_redirect got v=%0h addr=%0h h=%0h exp 0/10/1", out_valid, imem_addr, halted); end
      cycle();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFC;
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++; if (out_valid !== 1'b1 || out_pc !== 8'(8'hFC + 8'(4*k))) begin errors++; $display("FAIL wrap_pc[%0d] got v=%0h pc=%0h exp 1/%0h", k, out_valid, out_pc, 8'(8'hFC + 8'(4*k))); end
    end
  endtask

  task automatic test_random();
    for (int a = 0; a < 256; a++) begin
      rom[a] = $urandom;
      if ($urandom_range(15) == 0) rom[a][6:0] = 7'h7F;
    end
    do_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(11) == 0);
      redirect_pc    = 8'($urandom);
      halt           = (i == 350);
      checks++;
      if (out_valid !== (m_q.size() != 0) || count !== 3'(m_q.size()) ||
          full !== (m_q.size() == DEPTH) || imem_addr !== m_fpc || halted !== m_halted) begin
        errors++;
        $display("FAIL rand_state[%0d] got v=%0h c=%0d f=%0h a=%0h h=%0h exp c=%0d a=%0h h=%0h",
                 i, out_valid, count, full, imem_addr, halted, m_q.size(), m_fpc, m_halted);
      end
      if (m_q.size() != 0) begin
        checks++;
        if (out_pc !== m_q[0].pc || out_instr !== m_q[0].instr) begin
          errors++;
          $display("FAIL rand_head[%0d] got %0h/%0h exp %0h/%0h", i, out_pc, out_instr, m_q[0].pc, m_q[0].instr);
        end
      end
      cycle();
    end
    halt           = 1'b0;
    redirect_valid = 1'b0;
    rom_identity();
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    halt      = 1'b1;
    repeat (3) cycle();
    halt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0 || halted !== 1'b0 ||
        imem_addr !== 8'h00 || out_pc !== 8'h00 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got v=%0h c=%0d f=%0h h=%0h a=%0h pc=%0h i=%0h exp all 0",
               out_valid, count, full, halted, imem_addr, out_pc, out_instr);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h00) begin errors++; $display("FAIL async_restart got v=%0h pc=%0h exp 1/0", out_valid, out_pc); end
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    halt           = 1'b0;
    out_ready      = 1'b0;
    rom_identity();
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fetch_halt();
    test_halt();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
